// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF fetches and MEM loads/stores.
// Define MEM_ARB_TIMEOUT_EN to build the WAIT-state timeout abort and the sticky err flag.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_WAIT = 2'd1,
      D_WAIT  = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                last_d_q, last_d_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                if_done_q, if_done_d;
   logic                d_done_q, d_done_d;

   logic                d_req_c;
   logic                in_wait_c;
   logic                abort_c;

   assign d_req_c   = MemRead | MemWrite;
   assign in_wait_c = (state_q == IF_WAIT) || (state_q == D_WAIT);

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;

   // Expiry is the TIMEOUT-th ack-less WAIT cycle; an ack in that same cycle wins.
   assign abort_c = in_wait_c && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      cnt_d = '0;
      err_d = err_q | abort_c;
      if (in_wait_c && !mem_ack && !abort_c) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT;
   assign abort_c        = 1'b0;
   assign err            = 1'b0;
`endif

   // Grant, wait and response sequencing; all memory-side and pipeline-side outputs registered.
   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (d_req_c && !(last_d_q && if_req)) begin
               state_d     = D_WAIT;
               last_d_d    = 1'b1;
               mem_en_d    = 1'b1;
               mem_we_d    = MemWrite;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
            end else if (if_req) begin
               state_d     = IF_WAIT;
               last_d_d    = 1'b0;
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = d_wdata;
            end
         end

         IF_WAIT: begin
            if (mem_ack || abort_c) begin
               state_d    = RESP;
               mem_en_d   = 1'b0;
               mem_we_d   = 1'b0;
               if_done_d  = 1'b1;
               if_rdata_d = mem_ack ? mem_rdata : '0;
            end
         end

         D_WAIT: begin
            if (mem_ack || abort_c) begin
               state_d  = RESP;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               d_done_d = 1'b1;
               if (!mem_ack) begin
                  d_rdata_d = '0;
               end else if (!mem_we_q) begin
                  d_rdata_d = mem_rdata;
               end
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_done   = if_done_q;
   assign d_done    = d_done_q;

   // Stalls follow the live requests so a stage is released in its done cycle.
   assign stall_if  = if_req & ~if_done_q;
   assign stall_mem = d_req_c & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed latencies and data.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int TO = 15;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        stall_if;
   logic        stall_mem;
   logic        err;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int lat = 1;          // ack on the lat-th cycle of mem_en; 0 = never ack
   bit spurious = 1'b0;  // drive ack while mem_en is low

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .MemRead(MemRead), .MemWrite(MemWrite), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h40:  mem_word = 32'h5020_0001;
         32'h8:   mem_word = 32'h1234_5678;
         default: mem_word = a ^ 32'hA5A5_0000;
      endcase
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Memory responder: counts cycles of an active strobe and acks after lat of them.
   int en_cnt = 0;
   initial forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
         en_cnt++;
         mem_ack = (lat != 0) && (en_cnt == lat);
      end else begin
         en_cnt  = 0;
         mem_ack = spurious;
      end
      mem_rdata = mem_ack ? mem_word(mem_addr) : 32'h0;
   end

   // Reference model: one outstanding access, one idle response cycle, alternation after data.
   bit          m_busy, m_resp, m_last_d, m_is_d, m_en, m_we, m_if_done, m_d_done, m_err;
   logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
   int          m_wait;
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_busy = 0; m_resp = 0; m_last_d = 0; m_is_d = 0; m_en = 0; m_we = 0;
         m_if_done = 0; m_d_done = 0; m_err = 0; m_addr = '0; m_wdata = '0;
         m_if_rdata = '0; m_d_rdata = '0; m_wait = 0;
      end else begin
         m_if_done = 0;
         m_d_done  = 0;
         if (m_busy) begin
            m_wait++;
            if (mem_ack || (TMO && m_wait == TO)) begin
               m_busy = 0; m_resp = 1; m_en = 0;
               if (!mem_ack) m_err = 1;
               if (m_is_d) begin
                  m_d_done = 1;
                  if (!mem_ack) m_d_rdata = '0;
                  else if (!m_we) m_d_rdata = mem_word(m_addr);
               end else begin
                  m_if_done  = 1;
                  m_if_rdata = mem_ack ? mem_word(m_addr) : 32'h0;
               end
            end
         end else if (m_resp) begin
            m_resp = 0;
         end else if ((MemRead || MemWrite) && !(m_last_d && if_req)) begin
            m_busy = 1; m_en = 1; m_wait = 0; m_is_d = 1; m_last_d = 1;
            m_we = MemWrite; m_addr = d_addr; m_wdata = d_wdata;
         end else if (if_req) begin
            m_busy = 1; m_en = 1; m_wait = 0; m_is_d = 0; m_last_d = 0;
            m_we = 0; m_addr = if_addr; m_wdata = d_wdata;
         end
      end
   end

   // Cycle compare against the model, on the falling edge.
   initial forever begin
      @(negedge clk);
      check1("mem_en", mem_en, m_en);
      if (m_en) begin
         check1("mem_we", mem_we, m_we);
         check32("mem_addr", mem_addr, m_addr);
         check32("mem_wdata", mem_wdata, m_wdata);
      end
      check1("if_done", if_done, m_if_done);
      check1("d_done", d_done, m_d_done);
      check32("if_rdata", if_rdata, m_if_rdata);
      check32("d_rdata", d_rdata, m_d_rdata);
      check1("err", err, m_err);
      check1("stall_if", stall_if, if_req & ~m_if_done);
      check1("stall_mem", stall_mem, (MemRead | MemWrite) & ~m_d_done);
   end

   // Grant monitor: records each rising edge of mem_en.
   logic [31:0] g_addr[$];
   logic        g_we[$];
   logic [31:0] g_wd[$];
   int          g_cyc[$];
   int          en_hi = 0;
   bit          prev_en = 1'b0;
   initial forever begin
      @(negedge clk);
      if (mem_en && !prev_en) begin
         g_addr.push_back(mem_addr);
         g_we.push_back(mem_we);
         g_wd.push_back(mem_wdata);
         g_cyc.push_back(cyc);
      end
      if (mem_en) en_hi++;
      prev_en = mem_en;
   end

   task automatic clear_mon();
      g_addr.delete(); g_we.delete(); g_wd.delete(); g_cyc.delete();
      en_hi = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_done(input string name, input bit want_d, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (want_d ? d_done : if_done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         tests++;
         fails++;
         $display("FAIL %s: no done within %0d cycles", name, budget);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int k, at, nd, ni;
   initial begin
      // Reset values
      idle(3);
      check1("rst_mem_en", mem_en, 1'b0);
      check1("rst_if_done", if_done, 1'b0);
      check1("rst_d_done", d_done, 1'b0);
      check1("rst_err", err, 1'b0);
      check32("rst_mem_addr", mem_addr, 32'h0);
      check32("rst_if_rdata", if_rdata, 32'h0);
      check32("rst_d_rdata", d_rdata, 32'h0);
      rst = 1'b0;
      idle(2);

      // IF read with ack on the third strobe cycle
      lat = 3; clear_mon();
      if_req = 1; if_addr = 32'h40; k = cyc;
      wait_done("if_read", 1'b0, 20, at);
      if_req = 0;
      check_int("if_read_latency", at, k + 4);
      check32("if_read_rdata", if_rdata, 32'h5020_0001);
      check_int("if_read_en_cycles", en_hi, 3);
      check_int("if_read_grants", g_addr.size(), 1);
      if (g_addr.size() > 0) begin
         check32("if_read_addr", g_addr[0], 32'h40);
         check1("if_read_we", g_we[0], 1'b0);
      end

      // SW with immediate ack
      idle(2);
      lat = 1; clear_mon();
      MemWrite = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; k = cyc;
      wait_done("sw", 1'b1, 20, at);
      MemWrite = 0;
      check_int("sw_latency", at, k + 2);
      check32("sw_if_rdata_kept", if_rdata, 32'h5020_0001);
      check32("sw_d_rdata_kept", d_rdata, 32'h0);
      if (g_addr.size() > 0) begin
         check1("sw_we", g_we[0], 1'b1);
         check32("sw_wdata", g_wd[0], 32'hDEAD_BEEF);
         check32("sw_addr", g_addr[0], 32'h100);
      end

      // Plain fetch, 2-cycle memory; leaves last grant = IF
      idle(2);
      lat = 2;
      if_req = 1; if_addr = 32'h44; k = cyc;
      wait_done("fetch44", 1'b0, 20, at);
      if_req = 0;
      check_int("fetch44_latency", at, k + 3);
      check32("fetch44_rdata", if_rdata, 32'hA5A5_0044);

      // LW and fetch raised together: data first, fetch after the response cycle
      idle(2);
      lat = 1; clear_mon();
      MemRead = 1; d_addr = 32'h8; if_req = 1; if_addr = 32'h80; k = cyc;
      wait_done("lw_conc_d", 1'b1, 20, at);
      MemRead = 0;
      check_int("lw_conc_d_latency", at, k + 2);
      check32("lw_conc_d_rdata", d_rdata, 32'h1234_5678);
      wait_done("lw_conc_if", 1'b0, 20, at);
      if_req = 0;
      check_int("lw_conc_if_latency", at, k + 5);
      check32("lw_conc_if_rdata", if_rdata, 32'hA5A5_0080);
      check_int("lw_conc_grants", g_addr.size(), 2);
      if (g_addr.size() == 2) begin
         check32("lw_conc_first", g_addr[0], 32'h8);
         check32("lw_conc_second", g_addr[1], 32'h80);
         check_int("lw_conc_gap", g_cyc[1] - g_cyc[0], 3);
      end

      // Continuous contention: D, IF, D, IF, one grant every lat+2 cycles
      idle(2);
      lat = 2; clear_mon(); nd = 0; ni = 0;
      MemRead = 1; d_addr = 32'h200; if_req = 1; if_addr = 32'h300;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (d_done) nd++;
         if (if_done) ni++;
         if (nd + ni == 4) break;
      end
      MemRead = 0; if_req = 0;
      check_int("cont_d_dones", nd, 2);
      check_int("cont_if_dones", ni, 2);
      check_int("cont_grants", g_addr.size(), 4);
      if (g_addr.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check32("cont_order", g_addr[i], (i % 2 == 0) ? 32'h200 : 32'h300);
            if (i > 0) check_int("cont_spacing", g_cyc[i] - g_cyc[i-1], 4);
         end
      end

      // Stray ack while idle must be ignored
      idle(2);
      spurious = 1; nd = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (d_done || if_done || mem_en) nd++;
      end
      spurious = 0;
      check_int("spurious_ack_ignored", nd, 0);

      // Reset in the middle of a data access
      idle(2);
      lat = 0;
      MemRead = 1; d_addr = 32'h10;
      idle(3);
      check1("pre_rst_mem_en", mem_en, 1'b1);
      #2;
      rst = 1; MemRead = 0;
      #1;
      check1("midrst_mem_en", mem_en, 1'b0);
      check1("midrst_mem_we", mem_we, 1'b0);
      check1("midrst_d_done", d_done, 1'b0);
      check1("midrst_err", err, 1'b0);
      check1("midrst_stall_mem", stall_mem, 1'b0);
      check32("midrst_mem_addr", mem_addr, 32'h0);
      @(posedge clk); #1;
      rst = 0;
      idle(2);

      // After reset the alternation flag is clear: data wins again
      lat = 1; clear_mon();
      MemRead = 1; d_addr = 32'h8; if_req = 1; if_addr = 32'h84;
      wait_done("post_rst_d", 1'b1, 20, at);
      MemRead = 0;
      wait_done("post_rst_if", 1'b0, 20, at);
      if_req = 0;
      if (g_addr.size() > 0) check32("post_rst_first_grant", g_addr[0], 32'h8);

`ifdef MEM_ARB_TIMEOUT_EN
      // No ack: abort after 15 strobe cycles, rdata forced to 0, err sticky
      idle(2);
      lat = 0; clear_mon();
      MemRead = 1; d_addr = 32'h20; k = cyc;
      wait_done("tmo_abort", 1'b1, 40, at);
      MemRead = 0;
      check_int("tmo_abort_latency", at, k + 16);
      check32("tmo_abort_rdata", d_rdata, 32'h0);
      check1("tmo_abort_err", err, 1'b1);
      idle(5);
      check1("tmo_err_sticky", err, 1'b1);
      rst = 1; #1;
      check1("tmo_err_rst", err, 1'b0);
      @(posedge clk); #1;
      rst = 0;
      idle(2);

      // Ack on the expiry cycle completes normally
      lat = 15;
      MemRead = 1; d_addr = 32'h20; k = cyc;
      wait_done("tmo_edge", 1'b1, 40, at);
      MemRead = 0;
      check_int("tmo_edge_latency", at, k + 16);
      check32("tmo_edge_rdata", d_rdata, 32'hA5A5_0020);
      check1("tmo_edge_err", err, 1'b0);
`endif

      idle(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
